filter_decimate: RTL and testbench



---
 rtl/filter_decimate.sv | 166 ++++++++++++++++
 tb/tb_filter_decimate.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_decimate.sv
// Streaming 2:1 horizontal luma decimator, kernel [1 3 3 1]/8 across beat boundaries.
// Define FILTER_DECIMATE_ROUND_EN to add the +4 rounding term; otherwise results truncate.
module filter_decimate #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned PIX_N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W*PIX_N-1:0] in_pix,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [PIX_W*PIX_N-1:0] out_pix,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int unsigned W  = PIX_W * PIX_N;
  localparam int unsigned SW = PIX_W + 3;

  typedef enum logic [1:0] {S_A, S_B, S_LOOK} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [PIX_W-1:0] edge_q, edge_d;
  logic             ls_q, ls_d;
  logic             pend_q, pend_d;
  logic [W-1:0]     out_pix_q;
  logic             out_valid_q, out_last_q;

  logic             in_fire, emit, emit_last;
  logic [W-1:0]     fa, fb, filt;
  logic [PIX_W-1:0] pm1, p16;
  logic [PIX_W-1:0] px [2*PIX_N+2];
  logic [SW-1:0]    sum [PIX_N];

  assign in_ready  = (!out_valid_q || out_ready) && !pend_q;
  assign in_fire   = in_valid && in_ready;
  assign out_pix   = out_pix_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    edge_d    = edge_q;
    ls_d      = ls_q;
    pend_d    = pend_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    fa        = a_q;
    fb        = b_q;
    pm1       = edge_q;
    p16       = b_q[W-1 -: PIX_W];
    if (pend_q) begin
      // Deferred odd-beat tail of a line whose final beat arrived as a look-ahead.
      if (!out_valid_q || out_ready) begin
        emit      = 1'b1;
        emit_last = 1'b1;
        fb        = {PIX_N{a_q[W-1 -: PIX_W]}};
        p16       = a_q[W-1 -: PIX_W];
        pend_d    = 1'b0;
        ls_d      = 1'b1;
        state_d   = S_A;
      end
    end else if (in_fire) begin
      case (state_q)
        S_A: begin
          a_d    = in_pix;
          ls_d   = 1'b0;
          // The left neighbour of the pair is fixed here so later states need no flag.
          pm1    = ls_q ? in_pix[PIX_W-1:0] : edge_q;
          edge_d = pm1;
          if (in_last) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            fa        = in_pix;
            fb        = {PIX_N{in_pix[W-1 -: PIX_W]}};
            p16       = in_pix[W-1 -: PIX_W];
            ls_d      = 1'b1;
            state_d   = S_A;
          end else begin
            state_d = S_B;
          end
        end
        S_B: begin
          b_d = in_pix;
          if (in_last) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            fb        = in_pix;
            p16       = in_pix[W-1 -: PIX_W];
            ls_d      = 1'b1;
            state_d   = S_A;
          end else begin
            state_d = S_LOOK;
          end
        end
        S_LOOK: begin
          emit   = 1'b1;
          p16    = in_pix[PIX_W-1:0];
          edge_d = b_q[W-1 -: PIX_W];
          a_d    = in_pix;
          if (in_last) begin
            pend_d  = 1'b1;
            state_d = S_A;
          end else begin
            state_d = S_B;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_comb begin
    px[0]         = pm1;
    px[2*PIX_N+1] = p16;
    for (int unsigned i = 0; i < PIX_N; i++) begin
      px[i+1]       = fa[i*PIX_W +: PIX_W];
      px[i+1+PIX_N] = fb[i*PIX_W +: PIX_W];
    end
    filt = '0;
    for (int unsigned k = 0; k < PIX_N; k++) begin
      sum[k] = SW'(px[2*k]) + SW'(px[2*k+1]) * SW'(3)
             + SW'(px[2*k+2]) * SW'(3) + SW'(px[2*k+3]);
`ifdef FILTER_DECIMATE_ROUND_EN
      sum[k] = sum[k] + SW'(4);
`else
      sum[k] = sum[k];
`endif
      filt[k*PIX_W +: PIX_W] = sum[k][SW-1:3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      edge_q      <= '0;
      ls_q        <= 1'b1;
      pend_q      <= 1'b0;
      out_pix_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      edge_q  <= edge_d;
      ls_q    <= ls_d;
      pend_q  <= pend_d;
      if (emit) begin
        out_pix_q   <= filt;
        out_valid_q <= 1'b1;
        out_last_q  <= emit_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_decimate.sv
// Scoreboard bench for filter_decimate: directed lines push expected beats, a monitor pops and compares.
module tb_filter_decimate;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_pix;
  logic        in_valid, in_last, in_ready;
  logic [63:0] out_pix;
  logic        out_valid, out_last, out_ready;

  typedef struct packed {
    logic [63:0] pix;
    logic        last;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned errors = 0;
  int unsigned checks = 0;

`ifdef FILTER_DECIMATE_ROUND_EN
  localparam logic [63:0] RAMP0 = 64'h0F0D0B0907050301;
  localparam logic [63:0] RAMP1 = 64'h1E1D1B1917151311;
  localparam logic [63:0] ODD   = 64'h505050504A372310;
  localparam logic [63:0] R3B   = 64'h1717171716151311;
`else
  localparam logic [63:0] RAMP0 = 64'h0E0C0A0806040200;
  localparam logic [63:0] RAMP1 = 64'h1E1C1A1816141210;
  localparam logic [63:0] ODD   = 64'h5050505049372310;
  localparam logic [63:0] R3B   = 64'h1717171716141210;
`endif
  localparam logic [63:0] F80 = 64'h8080808080808080;
  localparam logic [63:0] FFF = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] F40 = 64'h4040404040404040;
  localparam logic [63:0] ODD_IN = 64'h50463C32281E140A;

  filter_decimate #(.PIX_W(8), .PIX_N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_pix   (in_pix),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_pix  (out_pix),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", out_pix);
        end else begin
          mon_e = q.pop_front();
          chk("out_pix", out_pix, mon_e.pix);
          chk("out_last", 64'(out_last), 64'(mon_e.last));
        end
      end else begin
        if (q.size() != 0) chk("stall_pix", out_pix, q[0].pix);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
    end
  end

  function automatic logic [63:0] ramp(input int unsigned j);
    logic [63:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i*8 +: 8] = 8'(8*j + i);
    return r;
  endfunction

  task automatic expect_beat(input logic [63:0] pix, input logic last);
    exp_t e;
    e.pix  = pix;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic send(input logic [63:0] pix, input logic last);
    int unsigned n;
    n        = 0;
    in_pix   = pix;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_pix", out_pix, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic ramp4();
    expect_beat(RAMP0, 1'b0);
    expect_beat(RAMP1, 1'b1);
    for (int unsigned j = 0; j < 4; j++) send(ramp(j), j == 3);
  endtask

  initial begin
    rst       = 1'b1;
    in_pix    = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    do_reset();

    // Flat line with latency checks
    expect_beat(F80, 1'b1);
    send(F80, 1'b0);
    chk("flat_no_early_valid", 64'(out_valid), 64'd0);
    send(F80, 1'b1);
    chk("flat_latency_valid", 64'(out_valid), 64'd1);
    drain();

    ramp4();
    drain();

    expect_beat(FFF, 1'b1);
    send(FFF, 1'b0);
    send(FFF, 1'b1);
    drain();

    // Backpressure: hold out_ready low five cycles once the first result appears
    out_ready = 1'b0;
    expect_beat(RAMP0, 1'b0);
    expect_beat(RAMP1, 1'b1);
    fork
      begin
        for (int unsigned j = 0; j < 4; j++) send(ramp(j), j == 3);
      end
      begin
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge clk);
        end
        if (!out_valid) begin
          checks++;
          errors++;
          $display("FAIL bp_wait_valid: out_valid got 0 expected 1");
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Odd-beat line, then a ramp that must restart with line-start replication
    expect_beat(ODD, 1'b1);
    send(ODD_IN, 1'b1);
    drain();
    ramp4();
    drain();

    // Three-beat line exercising the look-ahead beat that ends the line
    expect_beat(RAMP0, 1'b0);
    expect_beat(R3B, 1'b1);
    for (int unsigned j = 0; j < 3; j++) send(ramp(j), j == 2);
    drain();

    // Reset mid-line discards the partial pair
    send(FFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    expect_beat(F40, 1'b1);
    send(F40, 1'b0);
    send(F40, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
